// File: rtl/harmonic_tone_gen.sv
// harmonic_tone_gen: additive tone generator summing N_HARM sine partials.
// Partials are evaluated one per cycle through a shared quarter-wave sine
// table and a single multiplier, once per sample_en strobe.
// Optional feature: define HARMONIC_TONE_GEN_GLIDE_EN for pitch glide
// (f_eff slews toward freq by at most GLIDE_STEP per accepted sample).
module harmonic_tone_gen #(
    parameter int F_BITS     = 12,
    parameter int A_BITS     = 3,
    parameter int M_BITS     = 4,
    parameter int N_HARM     = 4,
    parameter int PHASE_BITS = 24,
    parameter int LUT_BITS   = 8,
    parameter int SIG_BITS   = 16,
    parameter int GLIDE_STEP = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [F_BITS-1:0]          freq,
    input  logic [N_HARM*A_BITS-1:0]   amp,
    input  logic [N_HARM*M_BITS-1:0]   mult,
    output logic [SIG_BITS-1:0]        out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned Q = 1 << LUT_BITS;
    localparam int H_BITS   = $clog2(N_HARM);
    localparam int SHIFT    = A_BITS + H_BITS;
    localparam int ACC_BITS = SIG_BITS + SHIFT;
    localparam int K_BITS   = (N_HARM > 1) ? H_BITS : 1;
    localparam int INC_BITS = F_BITS + M_BITS;
    // pi and full-scale amplitude in Q60 fixed point for table generation
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] AMAX   = (128'sd1 <<< (SIG_BITS - 1)) - 128'sd1;

    typedef enum logic [2:0] {IDLE, PHASE, ROM, MAC, OUT} state_t;

    // Table entry k = round(AMAX * sin(pi/2 * k/(Q-1))), evaluated at
    // elaboration with a Q60 Taylor series (error far below one LSB).
    function automatic logic [SIG_BITS-2:0] sine_entry(input int unsigned k);
        logic signed [127:0] x, x2, term, acc, div, scaled;
        x    = (PI_Q60 * 128'(k)) / 128'(2 * (Q - 1));
        x2   = (x * x) >>> 60;
        term = x;
        acc  = x;
        for (int unsigned n = 1; n <= 12; n++) begin
            div  = 128'((2 * n) * (2 * n + 1));
            term = -((term * x2) >>> 60) / div;
            acc  = acc + term;
        end
        scaled = (acc * AMAX + (128'sd1 <<< 59)) >>> 60;
        return scaled[SIG_BITS-2:0];
    endfunction

    state_t                      state, state_nx;
    logic [K_BITS-1:0]           k_idx;
    logic [PHASE_BITS-1:0]       phase [N_HARM];
    logic [F_BITS-1:0]           f_eff;
    logic [A_BITS-1:0]           amp_a [N_HARM];
    logic [M_BITS-1:0]           mult_a [N_HARM];
    logic [SIG_BITS-2:0]         rom_tab [Q];

    logic [INC_BITS-1:0]         inc;
    logic [PHASE_BITS-1:0]       phase_nx;
    logic [LUT_BITS+1:0]         top;
    logic [LUT_BITS-1:0]         addr;

    logic [LUT_BITS-1:0]         addr_r;
    logic                        sign1, sign2, v1, v2;
    logic [A_BITS-1:0]           amp1, amp2;
    logic [SIG_BITS-2:0]         mag_r;
    logic signed [SIG_BITS-1:0]  sample;
    logic signed [ACC_BITS-1:0]  prod, acc, acc_nx;

    for (genvar g = 0; g < Q; g++) begin : g_rom
        localparam logic [SIG_BITS-2:0] ENTRY = sine_entry(g);
        assign rom_tab[g] = ENTRY;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        out_valid = (state == OUT);
        case (state)
            IDLE:    if (sample_en) state_nx = PHASE;
            PHASE:   if (k_idx == K_BITS'(N_HARM - 1)) state_nx = ROM;
            ROM:     state_nx = MAC;
            MAC:     state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Phase advance and folded table address for the current partial
    always_comb begin
        inc      = f_eff * mult_a[k_idx];
        phase_nx = phase[k_idx] + PHASE_BITS'(inc);
        top      = phase_nx[PHASE_BITS-1 -: LUT_BITS+2];
        addr     = top[LUT_BITS] ? LUT_BITS'(Q - 1) - top[LUT_BITS-1:0]
                                 : top[LUT_BITS-1:0];
    end

    // Signed sample times drawbar amplitude, accumulated while stage 2 is valid
    always_comb begin
        sample = sign2 ? -$signed({1'b0, mag_r}) : $signed({1'b0, mag_r});
        prod   = ACC_BITS'(sample) * ACC_BITS'($signed({1'b0, amp2}));
        acc_nx = v2 ? acc + prod : acc;
    end

    // Datapath: latching, phase accumulators, table pipeline, accumulator, output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned h = 0; h < N_HARM; h++) begin
                phase[h]  <= '0;
                amp_a[h]  <= '0;
                mult_a[h] <= '0;
            end
            k_idx   <= '0;
            f_eff   <= '0;
            addr_r  <= '0;
            sign1   <= 1'b0;
            sign2   <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            amp1    <= '0;
            amp2    <= '0;
            mag_r   <= '0;
            acc     <= '0;
            out     <= '0;
            overrun <= 1'b0;
        end else begin
            v1    <= (state == PHASE);
            v2    <= v1;
            sign2 <= sign1;
            amp2  <= amp1;
            mag_r <= rom_tab[addr_r];
            acc   <= acc_nx;
            if (sample_en && state != IDLE) overrun <= 1'b1;
            if (state == MAC) out <= SIG_BITS'(acc_nx >>> SHIFT);
            case (state)
                IDLE: begin
                    k_idx <= '0;
                    if (sample_en) begin
                        for (int unsigned h = 0; h < N_HARM; h++) begin
                            amp_a[h]  <= amp[h*A_BITS +: A_BITS];
                            mult_a[h] <= mult[h*M_BITS +: M_BITS];
                        end
`ifdef HARMONIC_TONE_GEN_GLIDE_EN
                        if (freq > f_eff)
                            f_eff <= (freq - f_eff > F_BITS'(GLIDE_STEP))
                                     ? f_eff + F_BITS'(GLIDE_STEP) : freq;
                        else
                            f_eff <= (f_eff - freq > F_BITS'(GLIDE_STEP))
                                     ? f_eff - F_BITS'(GLIDE_STEP) : freq;
`else
                        f_eff <= freq;
`endif
                        acc <= '0;
                    end
                end
                PHASE: begin
                    phase[k_idx] <= phase_nx;
                    addr_r       <= addr;
                    sign1        <= top[LUT_BITS+1];
                    amp1         <= amp_a[k_idx];
                    k_idx        <= k_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_tone_gen.sv
// Directed self-checking bench for harmonic_tone_gen (PHASE_BITS=14 build).
module tb_harmonic_tone_gen;

    logic               clk = 1'b0;
    logic               reset, sample_en;
    logic [11:0]        freq;
    logic [11:0]        amp;
    logic [15:0]        mult;
    logic signed [15:0] out;
    logic               out_valid, busy, overrun;

    int checks = 0;
    int failures = 0;
    int fr;
    int am [4];
    int mm [4];
    int m_phase [4];
    int lat, o, e, cnt;
    logic b1, b_after, v_after;

    always #5 clk = ~clk;

    harmonic_tone_gen #(
        .F_BITS(12), .A_BITS(3), .M_BITS(4), .N_HARM(4),
        .PHASE_BITS(14), .LUT_BITS(8), .SIG_BITS(16), .GLIDE_STEP(4)
    ) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .freq(freq),
        .amp(amp), .mult(mult), .out(out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sine_val(input int ph);
        int top, addr, mag;
        real ang;
        top  = ph >> 4;
        addr = top & 255;
        if ((top & 256) != 0) addr = 255 - addr;
        ang  = 3.141592653589793 / 2.0 * real'(addr) / 255.0;
        mag  = $rtoi(32767.0 * $sin(ang) + 0.5);
        return ((top & 512) != 0) ? -mag : mag;
    endfunction

    task automatic model_step(output int ex);
        int sum;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            m_phase[k] = (m_phase[k] + fr * mm[k]) % 16384;
            sum += sine_val(m_phase[k]) * am[k];
        end
        ex = sum >>> 5;
    endtask

    task automatic apply();
        freq = 12'(fr);
        amp  = {3'(am[3]), 3'(am[2]), 3'(am[1]), 3'(am[0])};
        mult = {4'(mm[3]), 4'(mm[2]), 4'(mm[1]), 4'(mm[0])};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) m_phase[k] = 0;
    endtask

    task automatic run_sample(output int l, output int ov, output logic bf,
                              output logic ba, output logic va);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        bf = busy;
        l = 1;
        while (!out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
        ov = out;
        @(negedge clk);
        ba = busy;
        va = out_valid;
    endtask

    initial begin
        int exp_q [4];
        int glide_exp [4];
        exp_q = '{7167, 0, -7168, 0};
`ifdef HARMONIC_TONE_GEN_GLIDE_EN
        glide_exp = '{4, 8, 10, 10};
`else
        glide_exp = '{10, 10, 10, 10};
`endif
        reset = 1'b1; sample_en = 1'b0; freq = '0; amp = '0; mult = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) m_phase[k] = 0;

        // all amplitudes zero
        fr = 100; am = '{0, 0, 0, 0}; mm = '{1, 1, 1, 1}; apply();
        run_sample(lat, o, b1, b_after, v_after);
        chk("zero_latency", lat, 7);
        chk("zero_out", o, 0);
        chk("zero_busy_first", b1, 1);
        chk("zero_busy_after", b_after, 0);
        chk("zero_valid_after", v_after, 0);
        chk("zero_overrun", overrun, 0);

        // quarter-turn steps: +peak, 0, -peak, 0
        do_reset();
        fr = 1024; am = '{7, 0, 0, 0}; mm = '{4, 0, 0, 0}; apply();
        for (int i = 0; i < 4; i++) begin
            model_step(e);
            run_sample(lat, o, b1, b_after, v_after);
            chk("quad_latency", lat, 7);
            chk("quad_out", o, exp_q[i]);
            repeat (3) @(negedge clk);
            chk("quad_hold", out, exp_q[i]);
        end

        // high increment with phase wrap-around
        do_reset();
        fr = 4095; am = '{7, 0, 0, 0}; mm = '{15, 0, 0, 0}; apply();
        for (int i = 0; i < 100; i++) begin
            model_step(e);
            run_sample(lat, o, b1, b_after, v_after);
            chk("wrap_out", o, e);
        end
        chk("wrap_phase0", dut.phase[0], 14884);

        // four partials mixed
        do_reset();
        fr = 300; am = '{7, 3, 5, 1}; mm = '{1, 2, 3, 5}; apply();
        for (int i = 0; i < 20; i++) begin
            model_step(e);
            run_sample(lat, o, b1, b_after, v_after);
            chk("mix_out", o, e);
        end

        // sample_en while busy is ignored and sets sticky overrun
        do_reset();
        fr = 1024; am = '{7, 0, 0, 0}; mm = '{4, 0, 0, 0}; apply();
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        chk("ovr_flag", overrun, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ovr_first_out", out, 7167);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("ovr_no_extra", cnt, 0);
        chk("ovr_sticky", overrun, 1);
        run_sample(lat, o, b1, b_after, v_after);
        chk("ovr_next_out", o, 0);
        chk("ovr_still", overrun, 1);

        // reset in the middle of a computation
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out", out, 0);
        chk("midrst_overrun", overrun, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) m_phase[k] = 0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        run_sample(lat, o, b1, b_after, v_after);
        chk("midrst_restart", o, 7167);

        // effective pitch after a step from 0 to 10
        do_reset();
        fr = 10; am = '{0, 0, 0, 0}; mm = '{1, 0, 0, 0}; apply();
        for (int i = 0; i < 4; i++) begin
            run_sample(lat, o, b1, b_after, v_after);
            chk("glide_f_eff", dut.f_eff, glide_exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
